// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fb_arbiter
// Brief  : Single-port framebuffer RAM arbiter, fixed priority
//          video > posted-write buffer > CPU. Define FB_WRBUF_EN to enable
//          the posted-write buffer; without it CPU writes go through WAIT.
// Rev    : 1.0
// ============================================================================
module fb_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cpu_addr;
  logic                r_cpu_we;
  logic [DATA_W-1:0]   r_cpu_wdata;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [ADDR_W-1:0]   r_mem_addr_hold;
  logic                r_vid_valid;
  logic [15:0]         r_stall_cnt;

  logic                w_wb_empty;
  logic [ADDR_W-1:0]   w_wb_head_addr;
  logic [DATA_W-1:0]   w_wb_head_data;
  logic                w_post_idle;
  logic                w_post_wait;
  logic                w_wait_is_post;
  logic                w_gnt_vid, w_gnt_wb, w_gnt_cpu, w_cpu_done;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic                w_mem_we;
  logic [DATA_W-1:0]   w_mem_wdata;

  if (WB_DEPTH < 2 || (WB_DEPTH & (WB_DEPTH - 1)) != 0) begin : g_depth_check
    $error("fb_arbiter: WB_DEPTH must be a power of two and at least 2");
  end

`ifdef FB_WRBUF_EN
  localparam int c_PTR_W = $clog2(WB_DEPTH);
  localparam logic [c_PTR_W:0] c_WB_FULL = (c_PTR_W + 1)'(WB_DEPTH);

  logic [ADDR_W-1:0]  r_wb_addr [WB_DEPTH];
  logic [DATA_W-1:0]  r_wb_data [WB_DEPTH];
  logic [c_PTR_W-1:0] r_wb_wr, r_wb_rd;
  logic [c_PTR_W:0]   r_wb_cnt;
  logic               w_wb_full, w_wb_push, w_wb_pop;
  logic [ADDR_W-1:0]  w_push_addr;
  logic [DATA_W-1:0]  w_push_data;

  assign w_wb_empty     = (r_wb_cnt == '0);
  assign w_wb_full      = (r_wb_cnt == c_WB_FULL);
  assign w_wb_head_addr = r_wb_addr[r_wb_rd];
  assign w_wb_head_data = r_wb_data[r_wb_rd];
  assign w_post_idle    = (r_state == S_IDLE) && cpu_req && cpu_we && !w_wb_full;
  assign w_post_wait    = (r_state == S_WAIT) && r_cpu_we && !w_wb_full;
  // A write parked in WAIT only ever completes by entering the buffer.
  assign w_wait_is_post = r_cpu_we;
  assign w_wb_push      = w_post_idle || w_post_wait;
  assign w_wb_pop       = w_gnt_wb;
  assign w_push_addr    = (r_state == S_IDLE) ? cpu_addr  : r_cpu_addr;
  assign w_push_data    = (r_state == S_IDLE) ? cpu_wdata : r_cpu_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_wr  <= '0;
      r_wb_rd  <= '0;
      r_wb_cnt <= '0;
    end else begin
      if (w_wb_push) r_wb_wr <= r_wb_wr + 1'b1;
      if (w_wb_pop)  r_wb_rd <= r_wb_rd + 1'b1;
      if (w_wb_push && !w_wb_pop)      r_wb_cnt <= r_wb_cnt + 1'b1;
      else if (!w_wb_push && w_wb_pop) r_wb_cnt <= r_wb_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wb_push) begin
      r_wb_addr[r_wb_wr] <= w_push_addr;
      r_wb_data[r_wb_wr] <= w_push_data;
    end
  end
`else
  assign w_wb_empty     = 1'b1;
  assign w_wb_head_addr = '0;
  assign w_wb_head_data = '0;
  assign w_post_idle    = 1'b0;
  assign w_post_wait    = 1'b0;
  assign w_wait_is_post = 1'b0;
`endif

  // A CPU read waits for an empty buffer so it observes every posted write.
  assign w_gnt_vid  = vid_req;
  assign w_gnt_wb   = !vid_req && !w_wb_empty;
  assign w_gnt_cpu  = !vid_req && w_wb_empty && (r_state == S_WAIT) && !w_wait_is_post;
  assign w_cpu_done = w_gnt_cpu || w_post_wait;

  always_comb begin
    w_mem_addr  = r_mem_addr_hold;
    w_mem_we    = 1'b0;
    w_mem_wdata = '0;
    if (w_gnt_vid) begin
      w_mem_addr = vid_addr;
    end else if (w_gnt_wb) begin
      w_mem_addr  = w_wb_head_addr;
      w_mem_we    = 1'b1;
      w_mem_wdata = w_wb_head_data;
    end else if (w_gnt_cpu) begin
      w_mem_addr  = r_cpu_addr;
      w_mem_we    = r_cpu_we;
      w_mem_wdata = r_cpu_we ? r_cpu_wdata : '0;
    end
  end

  assign mem_addr  = reset ? '0 : w_mem_addr;
  assign mem_we    = reset ? 1'b0 : w_mem_we;
  assign mem_wdata = reset ? '0 : w_mem_wdata;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cpu_req) w_state_nxt = w_post_idle ? S_ACK : S_WAIT;
      S_WAIT:  if (w_cpu_done) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cpu_addr      <= '0;
      r_cpu_we        <= 1'b0;
      r_cpu_wdata     <= '0;
      r_cpu_rdata     <= '0;
      r_mem_addr_hold <= '0;
      r_vid_valid     <= 1'b0;
      r_stall_cnt     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_mem_addr_hold <= w_mem_addr;
      r_vid_valid     <= vid_req;
      if (r_state == S_IDLE && cpu_req) begin
        r_cpu_addr  <= cpu_addr;
        r_cpu_we    <= cpu_we;
        r_cpu_wdata <= cpu_wdata;
      end
      if (r_state == S_ACK && !r_cpu_we) r_cpu_rdata <= mem_rdata;
      if (r_state == S_WAIT && !w_cpu_done && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Read data is forwarded during the ack cycle, then held in r_cpu_rdata.
  assign cpu_rdata = (r_state == S_ACK && !r_cpu_we) ? mem_rdata : r_cpu_rdata;
  assign cpu_ack   = (r_state == S_ACK);
  assign vid_valid = r_vid_valid;
  assign vid_data  = mem_rdata;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// Testbench for fb_arbiter: behavioural 1-cycle RAM, directed CPU transaction
// table plus hand-timed sequences for scanout, posting, ordering, reset, saturation.
module tb_fb_arbiter;
  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;
  localparam int WB_DEPTH = 4;
`ifdef FB_WRBUF_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       stall_cnt;

  always #5 clk = ~clk;

  fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [7:0] pat(input logic [13:0] a);
    return a[7:0] ^ 8'hA5 ^ {2'b00, a[13:8]};
  endfunction

  // RAM model: unwritten locations read back the preload pattern.
  logic [7:0]  ram     [0:16383];
  bit          ram_vld [0:16383];
  logic        poke_en;
  logic [13:0] poke_addr;
  logic [7:0]  poke_data;
  logic [13:0] wlog_addr [$];
  logic [7:0]  wlog_data [$];

  function automatic logic [7:0] ram_peek(input logic [13:0] a);
    return ram_vld[a] ? ram[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    if (poke_en) begin
      ram[poke_addr]     <= poke_data;
      ram_vld[poke_addr] <= 1'b1;
    end
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      ram_vld[mem_addr] <= 1'b1;
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_wdata);
    end
    mem_rdata <= ram_peek(mem_addr);
  end

  int errors = 0, checks = 0, mon_bad = 0, exp_stall = 0;
  bit mon_en = 1'b0;
  logic exp_vv;

  always @(posedge clk or posedge reset)
    if (reset) exp_vv <= 1'b0;
    else       exp_vv <= vid_req;

  always @(negedge clk)
    if (mon_en && !reset && vid_valid !== exp_vv) mon_bad = mon_bad + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
    int          vid_cyc;
    int          exp_lat;
    logic [7:0]  exp_rdata;
    int          exp_stall;
  } txn_t;

  task automatic run_txn(input txn_t t, input int idx);
    bit got = 1'b0;
    int lat = -1;
    cpu_req = 1'b1; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata;
    for (int c = 0; c < t.vid_cyc + 40 && !got; c++) begin
      vid_req  = (c < t.vid_cyc);
      vid_addr = 14'(c);
      @(negedge clk);
      if (cpu_ack) begin
        got = 1'b1;
        lat = c;
        cpu_req = 1'b0;
        if (!t.we) chk($sformatf("txn%0d rdata at ack", idx), cpu_rdata, t.exp_rdata);
      end
      step();
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    chk($sformatf("txn%0d ack latency", idx), lat, t.exp_lat);
    exp_stall = sat16(exp_stall + t.exp_stall);
    @(negedge clk);
    chk($sformatf("txn%0d ack single pulse", idx), cpu_ack, 1'b0);
    chk($sformatf("txn%0d stall_cnt", idx), stall_cnt, exp_stall);
    if (!t.we) chk($sformatf("txn%0d rdata held", idx), cpu_rdata, t.exp_rdata);
    step();
  endtask

`ifdef FB_WRBUF_EN
  task automatic posted_write(input logic [13:0] a, input logic [7:0] d, input string nm);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    chk({nm, " no ack in request cycle"}, cpu_ack, 1'b0);
    step();
    @(negedge clk);
    chk({nm, " ack one cycle after request"}, cpu_ack, 1'b1);
    cpu_req = 1'b0;
    step();
  endtask
`endif

  txn_t tv [9];

  initial begin
    int scan_bad;
    int ws;
    bit got;
    tv[0] = '{1'b0, 14'h0123, 8'h00, 11, 12, 8'h5A, 10};
    tv[1] = '{1'b1, 14'h0200, 8'h11, 0, POSTED ? 1 : 2, 8'h00, 0};
    tv[2] = '{1'b0, 14'h0200, 8'h00, 0, 2, 8'h11, 0};
    tv[3] = '{1'b1, 14'h0201, 8'h22, 3, POSTED ? 1 : 4, 8'h00, POSTED ? 0 : 2};
    tv[4] = '{1'b0, 14'h0201, 8'h00, 0, 2, 8'h22, 0};
    tv[5] = '{1'b0, 14'h0005, 8'h00, 1, 2, pat(14'h0005), 0};
    tv[6] = '{1'b0, 14'h3FFF, 8'h00, 2, 3, pat(14'h3FFF), 1};
    tv[7] = '{1'b1, 14'h3FFF, 8'hC3, 2, POSTED ? 1 : 3, 8'h00, POSTED ? 0 : 1};
    tv[8] = '{1'b0, 14'h3FFF, 8'h00, 0, 2, 8'hC3, 0};

    reset = 1'b1; vid_req = 1'b1; vid_addr = 14'h155;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2AA; cpu_wdata = 8'hFF;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    repeat (3) step();
    @(negedge clk);
    chk("reset vid_valid", vid_valid, 1'b0);
    chk("reset cpu_ack", cpu_ack, 1'b0);
    chk("reset mem_we", mem_we, 1'b0);
    chk("reset mem_addr", mem_addr, 14'h0);
    chk("reset mem_wdata", mem_wdata, 8'h00);
    chk("reset cpu_rdata", cpu_rdata, 8'h00);
    chk("reset stall_cnt", stall_cnt, 16'h0);
    step();
    reset = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    mon_en = 1'b1;
    step();

    // Continuous scanout: data follows one cycle behind each address.
    scan_bad = 0;
    for (int i = 0; i <= 640; i++) begin
      vid_req  = (i < 640);
      vid_addr = 14'(i);
      @(negedge clk);
      if (i < 640 && (mem_addr !== 14'(i) || mem_we !== 1'b0)) scan_bad++;
      if (i > 0 && (vid_valid !== 1'b1 || vid_data !== pat(14'(i - 1)))) scan_bad++;
      step();
    end
    chk("scanout 640 data/address errors", scan_bad, 0);
    @(negedge clk);
    chk("scanout vid_valid drops", vid_valid, 1'b0);
    step();

    poke_en = 1'b1; poke_addr = 14'h0123; poke_data = 8'h5A;
    step();
    poke_en = 1'b0;

    for (int k = 0; k < 9; k++) run_txn(tv[k], k);
    chk("write through 0x3FFF landed", ram_peek(14'h3FFF), 8'hC3);

`ifdef FB_WRBUF_EN
    // Four posted writes under continuous video; the fifth waits for a slot.
    ws = wlog_addr.size();
    vid_req = 1'b1; vid_addr = 14'h0;
    for (int k = 0; k < 4; k++)
      posted_write(14'h0300 + 14'(k), 8'hB0 + 8'(k), $sformatf("post%0d", k));
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0304; cpu_wdata = 8'hB4;
    scan_bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cpu_ack !== 1'b0 || mem_we !== 1'b0) scan_bad++;
      step();
    end
    chk("fifth write blocked while full", scan_bad, 0);
    vid_req = 1'b0;
    @(negedge clk);
    chk("drain head addr", mem_addr, 14'h0300);
    chk("drain head data", mem_wdata, 8'hB0);
    chk("fifth no ack on drain cycle", cpu_ack, 1'b0);
    step();
    @(negedge clk);
    chk("drain second addr", mem_addr, 14'h0301);
    chk("fifth no ack on push cycle", cpu_ack, 1'b0);
    step();
    @(negedge clk);
    chk("fifth ack after slot frees", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    repeat (6) step();
    exp_stall = sat16(exp_stall + 6);
    chk("full-buffer stall_cnt", stall_cnt, exp_stall);
    chk("drain count", wlog_addr.size() - ws, 5);
    for (int k = 0; k < 5; k++) begin
      if (ws + k < wlog_addr.size()) begin
        chk($sformatf("drain order addr %0d", k), wlog_addr[ws + k], 14'h0300 + 14'(k));
        chk($sformatf("drain order data %0d", k), wlog_data[ws + k], 8'hB0 + 8'(k));
      end
    end

    // Read-after-write to the same address must wait for the drain.
    vid_req = 1'b1;
    posted_write(14'h0010, 8'hAA, "raw write");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
    repeat (3) step();
    vid_req = 1'b0;
    @(negedge clk);
    chk("raw drain we", mem_we, 1'b1);
    chk("raw drain addr", mem_addr, 14'h0010);
    chk("raw drain data", mem_wdata, 8'hAA);
    chk("raw read not yet acked", cpu_ack, 1'b0);
    step();
    @(negedge clk);
    chk("raw read grant we", mem_we, 1'b0);
    chk("raw read grant addr", mem_addr, 14'h0010);
    chk("raw read no early ack", cpu_ack, 1'b0);
    step();
    @(negedge clk);
    chk("raw read ack", cpu_ack, 1'b1);
    chk("raw read data", cpu_rdata, 8'hAA);
    cpu_req = 1'b0;
    step();
    exp_stall = sat16(exp_stall + 3);
    @(negedge clk);
    chk("raw stall_cnt", stall_cnt, exp_stall);
    step();
`endif

    // Reset while an access is pending in WAIT.
    vid_req = 1'b1; vid_addr = 14'h0;
`ifdef FB_WRBUF_EN
    posted_write(14'h0400, 8'h77, "pre-reset 0");
    posted_write(14'h0401, 8'h78, "pre-reset 1");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0402;
`else
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0400; cpu_wdata = 8'h77;
`endif
    repeat (3) step();
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset cpu_ack", cpu_ack, 1'b0);
    chk("mid reset mem_we", mem_we, 1'b0);
    chk("mid reset mem_addr", mem_addr, 14'h0);
    chk("mid reset stall_cnt", stall_cnt, 16'h0);
    step();
    reset = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
    exp_stall = 0;
    scan_bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cpu_ack !== 1'b0 || mem_we !== 1'b0) scan_bad++;
      step();
    end
    chk("post reset no ack/write", scan_bad, 0);
    chk("post reset ram 0x400", ram_peek(14'h0400), pat(14'h0400));
    chk("post reset ram 0x401", ram_peek(14'h0401), pat(14'h0401));

    // Long stall saturates the counter.
    vid_req = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0005;
    repeat (70000) step();
    @(negedge clk);
    chk("saturated stall_cnt", stall_cnt, 16'hFFFF);
    chk("long wait no ack", cpu_ack, 1'b0);
    step();
    vid_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        got = 1'b1;
        cpu_req = 1'b0;
        chk("long wait rdata", cpu_rdata, pat(14'h0005));
      end
      step();
    end
    chk("long wait eventually acked", got, 1'b1);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("stall_cnt stays saturated", stall_cnt, 16'hFFFF);
    step();

    chk("vid_valid timing errors", mon_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
